reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Debug-side reader for the 32×32 register bank. On a `start` pulse it asks the pipeline to stall, then reads every register in index order through a dedicated read port. It streams each value out over a valid/ready interface, followed by an XOR checksum word. It sits beside the register bank and gives a test harness or debug UART a coherent snapshot of architectural state.

## Interface
Parameters:
- `NUM_REGS`, 32, number of registers scanned (indices 0..NUM_REGS-1)
- `ADDR_W`, 5, register index width; NUM_REGS ≤ 2^ADDR_W
- `DATA_W`, 32, register data width

Ports:
- `clock` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high
- `start` in 1: dump request; sampled only in IDLE
- `stall_req` out 1: asks the pipeline to freeze register writes
- `stall_ack` in 1: pipeline confirms it is frozen
- `rd_addr` out ADDR_W: read index to the bank; combinational read
- `rd_data` in DATA_W: bank read data, valid in the same cycle as `rd_addr`
- `out_data` out DATA_W: streamed word
- `out_index` out ADDR_W: register index of `out_data`; 0 for the checksum word
- `out_last` out 1: marks the checksum word, which is the final beat
- `out_valid` out 1: `out_data`, `out_index` and `out_last` are valid
- `out_ready` in 1: consumer accepts the beat when `out_valid` and `out_ready` are both high
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse after the checksum beat is accepted

## Operation
- FSM states: IDLE, REQ, READ, SEND, CSUM, DONE.
- IDLE:
  - all outputs are 0
  - `start`=1 → REQ; clear index and checksum to 0
- REQ:
  - `stall_req`=1
  - stay until `stall_ack`=1 at a clock edge, then → READ
- READ:
  - `rd_addr`=index
  - at the edge: `out_data`←`rd_data`, `out_index`←index, checksum←checksum XOR `rd_data`
  - → SEND
- SEND:
  - `out_valid`=1; data, index and last are held stable until the beat is accepted
  - on handshake: if index = NUM_REGS-1 → CSUM; else index+1 → READ
- CSUM:
  - `out_valid`=1, `out_data`=checksum, `out_index`=0, `out_last`=1
  - on handshake → DONE
- DONE:
  - `done`=1 for one cycle
  - `stall_req` drops; → IDLE
- `stall_req` stays high from REQ through CSUM inclusive.
- `stall_ack` is ignored after the grant. While `stall_req` is high the pipeline must not deassert it.
- `start` is ignored outside IDLE, so no re-trigger and no queuing.
- Register 0 is read like any other register; no special casing.
- Index counter is ADDR_W bits and never wraps during a dump; the terminal compare is against NUM_REGS-1.

## Timing
- Reset value of every output is 0. Reset returns the FSM to IDLE and clears index and checksum.
- Reset mid-dump:
  - abandons the dump immediately, with no partial checksum and no `done`
  - drops `stall_req` asynchronously
- `start` at edge N → `stall_req`=1 from N+1.
- Grant at edge M → READ during cycle M+1; first `out_valid` in cycle M+2.
- With `out_ready` tied high:
  - each register costs 2 cycles (READ + SEND)
  - the full dump is 2·NUM_REGS + 1 (CSUM) + 1 (DONE) cycles after the grant, i.e. 66 cycles for 32 registers
- `out_ready` low holds SEND/CSUM indefinitely with outputs stable. `rd_addr` is don't-care outside READ and is driven 0.
- `out_valid` never depends combinationally on `out_ready`.

## Structure
- Shared package holds:
  - FSM state encoding (3-bit localparams for IDLE..DONE)
  - default NUM_REGS/ADDR_W/DATA_W constants, also used by the bank
- Single module, no sub-modules. The checksum accumulator and index counter are inline registers.

## Test plan
- Reset, then hold `start` low for 10 cycles → all outputs 0, `busy`=0.
- Bank preloaded with reg[i]=i·0x01010101, `stall_ack` returned 3 cycles after `stall_req`, `out_ready`=1. Required response:
  - 32 beats with index 0..31 and matching data
  - 33rd beat: `out_last`=1 with the XOR of all 32 values
  - `done` pulse one cycle later, then `stall_req`=0
- `out_ready` toggling 1,0,0,1… → no beat lost or duplicated; `out_data` stable while stalled; checksum unchanged from the previous scenario.
- `start` pulsed again at beat 10 → ignored; exactly one `done`.
- `reset` asserted during beat 15 → outputs 0 in the same cycle, no `done`. A new `start` yields a full, correct 33-beat dump.
- `stall_ack` held 0 for 50 cycles → stays in REQ, `busy`=1, `out_valid`=0. After the ack, the dump completes normally.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM encoding for the register-bank debug dump reader.
// The default sizes are also used by the register bank itself.
package reg_dump_reader_pkg;

  localparam int unsigned DefNumRegs = 32;
  localparam int unsigned DefAddrW   = 5;
  localparam int unsigned DefDataW   = 32;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StRead = 3'd2,
    StSend = 3'd3,
    StCsum = 3'd4,
    StDone = 3'd5
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Stalls the pipeline, reads every register in index order, and streams each value
// followed by an XOR checksum beat over a valid/ready interface.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              stall_req,
  input  logic              stall_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_index;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_csum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_index <= '0;
      r_data  <= '0;
      r_csum  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_index <= '0;
            r_csum  <= '0;
          end
        end
        StRead: begin
          r_data <= rd_data;
          r_csum <= r_csum ^ rd_data;
        end
        StSend: begin
          if (out_ready && (r_index != LastIdx)) begin
            r_index <= r_index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so everything is 0 in IDLE and during reset.
  always_comb begin
    w_state_next = r_state;
    stall_req    = 1'b0;
    rd_addr      = '0;
    out_data     = '0;
    out_index    = '0;
    out_last     = 1'b0;
    out_valid    = 1'b0;
    busy         = (r_state != StIdle);
    done         = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) w_state_next = StReq;
      end
      StReq: begin
        stall_req = 1'b1;
        if (stall_ack) w_state_next = StRead;
      end
      StRead: begin
        stall_req    = 1'b1;
        rd_addr      = r_index;
        w_state_next = StSend;
      end
      StSend: begin
        stall_req = 1'b1;
        out_valid = 1'b1;
        out_data  = r_data;
        out_index = r_index;
        if (out_ready) w_state_next = (r_index == LastIdx) ? StCsum : StRead;
      end
      StCsum: begin
        stall_req = 1'b1;
        out_valid = 1'b1;
        out_data  = r_csum;
        out_last  = 1'b1;
        if (out_ready) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: randomized bank contents, ack delay and
// backpressure, checked against beat lists computed directly from the bank array.
module tb_reg_dump_reader;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stall_ack = 1'b0;
  logic          out_ready = 1'b0;
  logic          stall_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] bank [N];
  assign rd_data = bank[rd_addr];

  always #5 clock = ~clock;

  reg_dump_reader #(
    .NUM_REGS (N),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stall_req (stall_req),
    .stall_ack (stall_ack),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] got_data [$];
  logic [AW-1:0] got_idx  [$];
  logic          got_last [$];
  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] exp_idx  [$];
  logic          exp_last [$];

  int done_cnt, unstable_cnt, req_bad_cnt, post_done_bad, reset_bad;
  int grant_neg, done_neg, first_valid_neg;
  bit timed_out;

  // Reference: one beat per register in order, then the XOR of all of them.
  task automatic build_expected();
    logic [DW-1:0] csum;
    csum = '0;
    exp_data.delete(); exp_idx.delete(); exp_last.delete();
    for (int i = 0; i < N; i++) begin
      exp_data.push_back(bank[i]);
      exp_idx.push_back(AW'(i));
      exp_last.push_back(1'b0);
      csum = csum ^ bank[i];
    end
    exp_data.push_back(csum);
    exp_idx.push_back('0);
    exp_last.push_back(1'b1);
  endtask

  // Drives one dump and records beats/events; ready_mode 0=always, 1=1,0,0,1 pattern, 2=random.
  task automatic run_dump(input int ack_delay, input int ready_mode, input int restart_beat,
                          input int reset_beat);
    int neg, req_cycles;
    bit held, finished;
    logic [DW-1:0] held_d;
    logic [AW-1:0] held_i;
    logic held_l;
    got_data.delete(); got_idx.delete(); got_last.delete();
    done_cnt = 0; unstable_cnt = 0; req_bad_cnt = 0; post_done_bad = 0; reset_bad = 0;
    grant_neg = -1; done_neg = -1; first_valid_neg = -1; timed_out = 0;
    neg = 0; req_cycles = 0; held = 0; finished = 0;
    held_d = '0; held_i = '0; held_l = 1'b0;
    @(negedge clock);
    start = 1'b1;
    while (!finished) begin
      @(negedge clock);
      neg++;
      start = 1'b0;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((neg % 4) == 0) || ((neg % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall_req) begin
        req_cycles++;
        if (req_cycles > ack_delay) stall_ack = 1'b1;
      end else begin
        stall_ack = 1'b0;
      end
      #1;
      if (stall_req && !stall_ack && (!busy || out_valid)) req_bad_cnt++;
      if (stall_req && stall_ack && grant_neg < 0) grant_neg = neg;
      if (reset_beat >= 0 && out_valid && !out_last && int'(out_index) == reset_beat) begin
        reset = 1'b1;
        #1;
        if (stall_req || busy || done || out_valid || out_last || out_data != '0 ||
            out_index != '0 || rd_addr != '0) reset_bad = 1;
        @(negedge clock);
        reset = 1'b0;
        stall_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clock);
          if (done) done_cnt++;
          if (busy || stall_req) reset_bad = 1;
        end
        finished = 1;
      end else begin
        if (out_valid) begin
          if (first_valid_neg < 0) first_valid_neg = neg;
          if (held && (out_data !== held_d || out_index !== held_i || out_last !== held_l))
            unstable_cnt++;
          if (out_ready) begin
            got_data.push_back(out_data);
            got_idx.push_back(out_index);
            got_last.push_back(out_last);
            held = 0;
            if (got_data.size() == restart_beat) start = 1'b1;
          end else begin
            held = 1; held_d = out_data; held_i = out_index; held_l = out_last;
          end
        end else if (held) begin
          unstable_cnt++;
          held = 0;
        end
        if (done) begin
          done_cnt++;
          if (done_neg < 0) done_neg = neg;
        end
        if (done_neg >= 0 && neg == done_neg + 1 && (stall_req || done)) post_done_bad++;
        if (done_neg >= 0 && neg >= done_neg + 4) finished = 1;
      end
      if (neg > 3000) begin
        timed_out = 1;
        finished = 1;
      end
    end
    stall_ack = 1'b0;
    out_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    #12;
    n_checks++;
    if ({stall_req, busy, done, out_valid, out_last} !== 5'b0 || out_data !== '0)
      $display("FAIL reset_hold: outputs busy=%0b valid=%0b data=%0h, required all 0",
               busy, out_valid, out_data);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (stall_req || busy || done || out_valid || out_last || out_data != '0 ||
          out_index != '0 || rd_addr != '0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL idle_outputs: %0d nonzero cycles, required 0", bad);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %0b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < N; i++) bank[i] = 32'(i) * 32'h0101_0101;
    build_expected();
    run_dump(3, 0, -1, -1);
    n_checks++;
    if (timed_out || got_data.size() != exp_data.size())
      $display("FAIL full_beats: got %0d beats required %0d", got_data.size(), exp_data.size());
    else n_pass++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i])
        $display("FAIL full_beat%0d: got %0h/%0d/%0b required %0h/%0d/%0b", i, got_data[i],
                 got_idx[i], got_last[i], exp_data[i], exp_idx[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt !== 1) $display("FAIL full_done: got %0d pulses required 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (post_done_bad !== 0) $display("FAIL full_stall_drop: got %0d required 0", post_done_bad);
    else n_pass++;
    n_checks++;
    if (done_neg - grant_neg !== 66)
      $display("FAIL full_latency: got %0d cycles required 66", done_neg - grant_neg);
    else n_pass++;
    n_checks++;
    if (first_valid_neg - grant_neg !== 2)
      $display("FAIL first_valid: got %0d cycles required 2", first_valid_neg - grant_neg);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_dump(3, 1, -1, -1);
    n_checks++;
    if (timed_out || got_data.size() != exp_data.size())
      $display("FAIL bp_beats: got %0d beats required %0d", got_data.size(), exp_data.size());
    else n_pass++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i])
        $display("FAIL bp_beat%0d: got %0h/%0d required %0h/%0d", i, got_data[i], got_idx[i],
                 exp_data[i], exp_idx[i]);
      else n_pass++;
    end
    n_checks++;
    if (unstable_cnt !== 0) $display("FAIL bp_stable: got %0d changes required 0", unstable_cnt);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL bp_done: got %0d pulses required 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_restart_ignored();
    run_dump(1, 0, 10, -1);
    n_checks++;
    if (timed_out || got_data.size() != exp_data.size())
      $display("FAIL restart_beats: got %0d required %0d", got_data.size(), exp_data.size());
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL restart_done: got %0d pulses required 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (got_data.size() > 0 && got_data[got_data.size()-1] !== exp_data[N])
      $display("FAIL restart_csum: got %0h required %0h", got_data[got_data.size()-1], exp_data[N]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    run_dump(2, 0, -1, 15);
    n_checks++;
    if (reset_bad !== 0) $display("FAIL midreset_outputs: got %0d required 0", reset_bad);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 0) $display("FAIL midreset_done: got %0d pulses required 0", done_cnt);
    else n_pass++;
    n_checks++;
    if (got_data.size() != 15) $display("FAIL midreset_beats: got %0d required 15", got_data.size());
    else n_pass++;
    for (int i = 0; i < N; i++) bank[i] = $urandom;
    build_expected();
    run_dump(2, 2, -1, -1);
    n_checks++;
    if (timed_out || got_data.size() != exp_data.size())
      $display("FAIL redump_beats: got %0d required %0d", got_data.size(), exp_data.size());
    else n_pass++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i])
        $display("FAIL redump_beat%0d: got %0h/%0d required %0h/%0d", i, got_data[i], got_idx[i],
                 exp_data[i], exp_idx[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt !== 1) $display("FAIL redump_done: got %0d pulses required 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_ack_delay();
    for (int i = 0; i < N; i++) bank[i] = $urandom;
    build_expected();
    run_dump(50, 0, -1, -1);
    n_checks++;
    if (req_bad_cnt !== 0) $display("FAIL ack_wait: got %0d bad cycles required 0", req_bad_cnt);
    else n_pass++;
    n_checks++;
    if (grant_neg < 50) $display("FAIL ack_grant: grant at cycle %0d required >= 50", grant_neg);
    else n_pass++;
    n_checks++;
    if (timed_out || got_data.size() != exp_data.size() || got_data[N] !== exp_data[N])
      $display("FAIL ack_dump: got %0d beats required %0d", got_data.size(), exp_data.size());
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL ack_done: got %0d pulses required 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) bank[i] = $urandom;
      build_expected();
      run_dump(int'($urandom_range(0, 5)), 2, -1, -1);
      errs = 0;
      if (got_data.size() != exp_data.size()) errs++;
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
        if (got_data[i] !== exp_data[i] || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i])
          errs++;
      n_checks++;
      if (timed_out || errs != 0 || unstable_cnt != 0 || done_cnt != 1)
        $display("FAIL random%0d: %0d beat errors, %0d unstable, %0d done, required 0/0/1",
                 r, errs, unstable_cnt, done_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) bank[i] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_ack_delay();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
